macc_dot_seq: RTL and testbench
===============================

// Module: macc_dot_seq
// PURPOSE
//  Job sequencer for the shared 18x18 DSP48E multiply-accumulate (macc18x18) datapath.
//  Accepts a dot-product job of LEN sample pairs and clears the MACC accumulator.
//  Streams the operands into the MACC through a valid/ready port, waits out the pipeline,
//  then returns the 48-bit accumulated result on a valid/ready result port.
//  Sits between the filter/correlator control logic and the macc18x18 instance.
// PARAMETERS
//  MACC_LAT  4   cycles from MACC operand inputs to that product appearing in MACC_P
//  LEN_W     10  width of the job length field
//  CLR_CYC   2   cycles MACC_RST is held high to clear the accumulator
// PORTS
//  CLK           in   1      clock, all logic on rising edge
//  RST           in   1      synchronous reset, ACTIVE-LOW (0 = reset)
//  START         in   1      job request, sampled only when BUSY=0
//  LEN           in   LEN_W  number of products in the job, latched with START
//  BUSY          out  1      job in progress (CLEAR/RUN/DRAIN/DONE)
//  S_VALID       in   1      operand pair valid
//  S_READY       out  1      sequencer accepts operand pair
//  S_A           in   18     multiplicand, two's complement
//  S_B           in   18     multiplier, two's complement
//  S_SUB         in   1      1 = subtract this product, 0 = add
//  MACC_RST      out  1      active-high clear to the MACC
//  MACC_A        out  18     MACC A operand (registered)
//  MACC_B        out  18     MACC B operand (registered)
//  MACC_ADD_SUB  out  1      MACC add/subtract select (registered)
//  MACC_P        in   48     MACC accumulator output
//  R_VALID       out  1      result valid
//  R_READY       in   1      result consumer ready
//  R_DATA        out  48     accumulated result
// BEHAVIOUR
//  Reset (RST=0 at an edge): state=IDLE, BUSY=0, S_READY=0, MACC_RST=1, MACC_A/B=0,
//   MACC_ADD_SUB=0, R_VALID=0, R_DATA=0. Reset mid-job abandons the job, no result is issued.
//  FSM states and transitions: IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: MACC_RST=0, operands 0. START=1 latches LEN into the remaining counter; next state CLEAR.
//  CLEAR: MACC_RST=1 for exactly CLR_CYC cycles with operands 0.
//   Next state is RUN if LEN!=0, else DRAIN.
//  RUN: S_READY=1, decoded from the state register. A transfer happens when S_VALID & S_READY.
//   On a transfer, the next edge loads MACC_A/B/ADD_SUB from S_A/S_B/S_SUB and decrements remaining.
//   On a non-transfer cycle, the next edge loads MACC_A=MACC_B=0 and ADD_SUB=0, so a bubble adds zero.
//   The transfer with remaining==1 moves the FSM to DRAIN, so S_READY=0 on the following cycle.
//  DRAIN: operands 0. The drain counter waits MACC_LAT+1 cycles (operand register plus MACC latency).
//   On its last cycle, MACC_P is captured into R_DATA, R_VALID is set, and the FSM moves to DONE.
//  DONE: R_VALID=1. R_DATA is held stable until R_VALID & R_READY; on that edge R_VALID=0 and the FSM moves to IDLE.
//  BUSY=1 in every state except IDLE. START while BUSY=1 is ignored, including in the R_READY handshake cycle.
//  A new START is honoured in IDLE, at the earliest the cycle after the result handshake.
//  Arithmetic: operands are passed unmodified; sign and 48-bit accumulation are done by the MACC.
//   No saturation; overflow wraps mod 2^48.
//  LEN=0: the job completes with R_DATA = cleared accumulator (0).
// TESTING
//  Bench uses a behavioural MACC model with latency MACC_LAT, clear on MACC_RST, and P += (SUB ? -A*B : A*B).
//  T1: LEN=1, (512,512,+) -> one R_VALID pulse with R_DATA=48'h000000040000; BUSY=0 after handshake.
//  T2: LEN=4, (512,512,+) (2020,2020,+) (10,10,-) (1115,1115,-), S_VALID always 1 -> R_DATA=48'h0000002F4A53.
//  T3: T2 operands with S_VALID low on alternate cycles -> same R_DATA 48'h2F4A53; exactly 4 transfers.
//  T4: T2 with R_READY low 10 cycles -> R_VALID/R_DATA stable, S_READY=0, START pulses ignored; one result only.
//  T5: LEN=0 -> R_VALID after CLEAR and DRAIN with R_DATA=0; S_READY never asserted.
//  T6: RST=0 for 1 cycle after 2 transfers of T2 -> all outputs at reset values next edge, no R_VALID;
//      rerun T2 -> 48'h2F4A53.

Source files
------------

// File: rtl/macc_dot_seq.sv
// ---------------------------------------------------------------------------
// macc_dot_seq
// Job sequencer for a shared 18x18 multiply-accumulate datapath. A START
// accepts a dot-product job of LEN operand pairs. The sequencer first clears
// the accumulator, then streams the operand pairs into the MACC. It waits for
// the MACC pipeline to empty and finally returns the 48-bit result on a
// valid/ready port.
//
// Ports
//   CLK, RST          clock (rising edge), synchronous active-low reset
//   START, LEN, BUSY  job request, job length, job-in-progress flag
//   S_VALID/S_READY   operand stream handshake
//   S_A, S_B, S_SUB   operand pair and add(0)/subtract(1) select
//   MACC_RST          active-high accumulator clear
//   MACC_A/B/ADD_SUB  registered operands towards the MACC
//   MACC_P            MACC accumulator output
//   R_VALID/R_READY   result handshake
//   R_DATA            accumulated result, held until handshake
// ---------------------------------------------------------------------------
module macc_dot_seq #(
    parameter int MACC_LAT = 4,
    parameter int LEN_W    = 10,
    parameter int CLR_CYC  = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    output logic             BUSY,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [17:0]      S_A,
    input  logic [17:0]      S_B,
    input  logic             S_SUB,
    output logic             MACC_RST,
    output logic [17:0]      MACC_A,
    output logic [17:0]      MACC_B,
    output logic             MACC_ADD_SUB,
    input  logic [47:0]      MACC_P,
    output logic             R_VALID,
    input  logic             R_READY,
    output logic [47:0]      R_DATA
);

    localparam int CLR_W = $clog2(CLR_CYC + 1);
    localparam int DRN_W = $clog2(MACC_LAT + 2);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [CLR_W-1:0] clr_cnt;
    logic [DRN_W-1:0] drn_cnt;
    logic             xfer;
    logic             clr_last;
    logic             drn_last;

    assign S_READY  = (state == RUN);
    assign BUSY     = (state != IDLE);
    assign xfer     = S_VALID & S_READY;
    assign clr_last = (clr_cnt == CLR_W'(CLR_CYC - 1));
    // One cycle for the operand register plus the MACC pipeline depth.
    assign drn_last = (drn_cnt == DRN_W'(MACC_LAT));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (START) state_nxt = CLEAR;
            CLEAR: if (clr_last) state_nxt = (remaining != '0) ? RUN : DRAIN;
            RUN:   if (xfer && remaining == LEN_W'(1)) state_nxt = DRAIN;
            DRAIN: if (drn_last) state_nxt = DONE;
            DONE:  if (R_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= IDLE;
            remaining    <= '0;
            clr_cnt      <= '0;
            drn_cnt      <= '0;
            MACC_RST     <= 1'b1;
            MACC_A       <= '0;
            MACC_B       <= '0;
            MACC_ADD_SUB <= 1'b0;
            R_VALID      <= 1'b0;
            R_DATA       <= '0;
        end else begin
            state <= state_nxt;
            // Registered from the next state so the clear lines up exactly
            // with the CLEAR cycles.
            MACC_RST <= (state_nxt == CLEAR);

            // Bubbles feed zero operands so they contribute nothing.
            MACC_A       <= xfer ? S_A   : '0;
            MACC_B       <= xfer ? S_B   : '0;
            MACC_ADD_SUB <= xfer ? S_SUB : 1'b0;

            if (state == IDLE && START)
                remaining <= LEN;
            else if (xfer)
                remaining <= remaining - LEN_W'(1);

            clr_cnt <= (state == CLEAR) ? clr_cnt + CLR_W'(1) : '0;
            drn_cnt <= (state == DRAIN) ? drn_cnt + DRN_W'(1) : '0;

            if (state == DRAIN && drn_last) begin
                R_VALID <= 1'b1;
                R_DATA  <= MACC_P;
            end else if (state == DONE && R_READY) begin
                R_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_macc_dot_seq.sv
// ---------------------------------------------------------------------------
// tb_macc_dot_seq
// Self-checking bench for macc_dot_seq. It contains a behavioural MACC, which
// is a product delay line feeding an accumulator. It also contains a
// job-level reference model, against which every output is compared on
// every cycle. Directed jobs and randomized jobs follow.
// ---------------------------------------------------------------------------
module tb_macc_dot_seq;

    localparam int MACC_LAT = 4;
    localparam int LEN_W    = 10;
    localparam int CLR_CYC  = 2;

    logic             CLK = 0, RST = 0, START = 0;
    logic [LEN_W-1:0] LEN = '0;
    logic             BUSY, S_READY, MACC_RST, MACC_ADD_SUB, R_VALID;
    logic             S_VALID = 0, S_SUB = 0, R_READY = 0;
    logic [17:0]      S_A = '0, S_B = '0, MACC_A, MACC_B;
    logic [47:0]      MACC_P, R_DATA;

    macc_dot_seq #(.MACC_LAT(MACC_LAT), .LEN_W(LEN_W), .CLR_CYC(CLR_CYC)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .BUSY(BUSY),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B), .S_SUB(S_SUB),
        .MACC_RST(MACC_RST), .MACC_A(MACC_A), .MACC_B(MACC_B),
        .MACC_ADD_SUB(MACC_ADD_SUB), .MACC_P(MACC_P),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] prod(input logic [17:0] a, input logic [17:0] b, input logic s);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        if (s) p = -p;
        return p[47:0];
    endfunction

    // Behavioural MACC: a product sampled at an edge shows in P MACC_LAT-1
    // edges later, which is MACC_LAT cycles after its operand cycle.
    logic [47:0] dly [MACC_LAT-1];
    logic [47:0] p_acc = '0;
    assign MACC_P = p_acc;
    always @(posedge CLK) begin
        if (MACC_RST) begin
            p_acc <= '0;
            for (int i = 0; i < MACC_LAT - 1; i++) dly[i] <= '0;
        end else begin
            dly[0] <= prod(MACC_A, MACC_B, MACC_ADD_SUB);
            for (int i = 1; i < MACC_LAT - 1; i++) dly[i] <= dly[i-1];
            p_acc <= p_acc + dly[MACC_LAT-2];
        end
    end

    // Job-level reference model: phase plus cycle countdowns taken from the
    // behavioural rules. The result is the plain signed sum of the accepted
    // products.
    localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;
    int          m_ph = P_IDLE, m_rem = 0, m_cl = 0, m_dr = 0;
    logic        m_mrst = 1, m_rv = 0, m_sub = 0;
    logic [17:0] m_a = '0, m_b = '0;
    logic [47:0] m_acc = '0, m_rd = '0;

    always @(posedge CLK) begin
        m_a <= '0; m_b <= '0; m_sub <= 1'b0;
        if (!RST) begin
            m_ph <= P_IDLE; m_rv <= 1'b0; m_rd <= '0; m_mrst <= 1'b1;
        end else begin
            case (m_ph)
                P_IDLE: begin
                    m_mrst <= 1'b0;
                    if (START) begin
                        m_rem <= int'(LEN); m_cl <= CLR_CYC; m_ph <= P_CLEAR;
                        m_mrst <= 1'b1; m_acc <= '0;
                    end
                end
                P_CLEAR: begin
                    if (m_cl == 1) begin
                        m_ph <= (m_rem != 0) ? P_RUN : P_DRAIN;
                        m_dr <= MACC_LAT + 1; m_mrst <= 1'b0;
                    end else m_cl <= m_cl - 1;
                end
                P_RUN: if (S_VALID) begin
                    m_a <= S_A; m_b <= S_B; m_sub <= S_SUB;
                    m_acc <= m_acc + prod(S_A, S_B, S_SUB);
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin m_ph <= P_DRAIN; m_dr <= MACC_LAT + 1; end
                end
                P_DRAIN: begin
                    if (m_dr == 1) begin m_ph <= P_DONE; m_rv <= 1'b1; m_rd <= m_acc; end
                    else m_dr <= m_dr - 1;
                end
                P_DONE: if (R_READY) begin m_rv <= 1'b0; m_ph <= P_IDLE; end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    // Event counters observed on the DUT pins.
    int hs_cnt = 0, xfer_cnt = 0, sready_cnt = 0, rvalid_cnt = 0;
    always @(posedge CLK) begin
        if (R_VALID && R_READY) hs_cnt <= hs_cnt + 1;
        if (S_VALID && S_READY) xfer_cnt <= xfer_cnt + 1;
        if (S_READY) sready_cnt <= sready_cnt + 1;
        if (R_VALID) rvalid_cnt <= rvalid_cnt + 1;
    end

    bit chk_en = 0;
    always @(negedge CLK) if (chk_en) begin
        cmp("busy",     BUSY,         m_ph != P_IDLE);
        cmp("s_ready",  S_READY,      m_ph == P_RUN);
        cmp("macc_rst", MACC_RST,     m_mrst);
        cmp("macc_a",   MACC_A,       m_a);
        cmp("macc_b",   MACC_B,       m_b);
        cmp("macc_sub", MACC_ADD_SUB, m_sub);
        cmp("r_valid",  R_VALID,      m_rv);
        cmp("r_data",   R_DATA,       m_rd);
    end

    // Stimulus
    logic [17:0] qa[$], qb[$];
    logic        qs[$];
    int          qi = 0;

    task automatic clr_q(); qa.delete(); qb.delete(); qs.delete(); qi = 0; endtask
    task automatic push(input logic [17:0] a, input logic [17:0] b, input logic s);
        qa.push_back(a); qb.push_back(b); qs.push_back(s);
    endtask
    task automatic load_t2();
        clr_q();
        push(18'd512, 18'd512, 0); push(18'd2020, 18'd2020, 0);
        push(18'd10, 18'd10, 1);   push(18'd1115, 18'd1115, 1);
    endtask

    task automatic start_job(input int len);
        START = 1; LEN = LEN_W'(len);
        @(posedge CLK); #1;
        START = 0; LEN = LEN_W'($urandom);
    endtask

    // vmode: 0 = always valid, 1 = alternate, 2 = random
    task automatic feed(input int n, input int vmode);
        int  k = 0, guard = 0;
        bit  tog = 1, go;
        while (k < n && guard < 400) begin
            S_VALID = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            S_A   = S_VALID ? qa[qi] : 18'($urandom);
            S_B   = S_VALID ? qb[qi] : 18'($urandom);
            S_SUB = S_VALID ? qs[qi] : 1'($urandom);
            @(negedge CLK); go = S_VALID && S_READY;
            @(posedge CLK); #1;
            if (go) begin k++; qi++; end
            guard++;
        end
        S_VALID = 0; S_A = '0; S_B = '0; S_SUB = 0;
        if (k < n) cmp("feed_timeout", k, n);
    endtask

    task automatic finish_job(input int rdelay, input bit noise, output logic [47:0] res);
        bit got = 0;
        for (int g = 0; g < 100 && !got; g++) begin @(negedge CLK); got = R_VALID; end
        if (!got) cmp("rvalid_timeout", got, 1);
        res = R_DATA;
        for (int d = 0; d < rdelay; d++) begin
            R_READY = 0; START = noise;
            @(negedge CLK);
            if (noise) cmp("hold_rdata", R_DATA, res);
        end
        R_READY = 1; START = noise;
        @(posedge CLK); #1;
        R_READY = 0; START = 0;
        @(negedge CLK);
        cmp("busy_after_hs", BUSY, 0);
        cmp("rvalid_after_hs", R_VALID, 0);
    endtask

    logic [47:0] res;
    int h0, x0, s0, v0;

    initial begin
        @(posedge CLK); #1; chk_en = 1;
        @(negedge CLK);
        cmp("rst_busy", BUSY, 0); cmp("rst_macc_rst", MACC_RST, 1);
        cmp("rst_rvalid", R_VALID, 0); cmp("rst_rdata", R_DATA, 0);
        @(posedge CLK); #1; RST = 1;

        // T1
        clr_q(); push(18'd512, 18'd512, 0); h0 = hs_cnt;
        start_job(1); feed(1, 0); finish_job(0, 0, res);
        cmp("t1_rdata", res, 48'h000000040000);
        cmp("t1_model", m_rd, 48'h000000040000);
        cmp("t1_results", hs_cnt - h0, 1);

        // T2
        load_t2(); start_job(4); feed(4, 0); finish_job(0, 0, res);
        cmp("t2_rdata", res, 48'h0000002F4A53);

        // T3
        load_t2(); x0 = xfer_cnt;
        start_job(4); feed(4, 1); finish_job(0, 0, res);
        cmp("t3_rdata", res, 48'h2F4A53);
        cmp("t3_xfers", xfer_cnt - x0, 4);

        // T4
        load_t2(); h0 = hs_cnt;
        start_job(4); feed(4, 0); finish_job(10, 1, res);
        cmp("t4_rdata", res, 48'h2F4A53);
        cmp("t4_results", hs_cnt - h0, 1);
        repeat (3) @(posedge CLK);
        cmp("t4_no_restart", BUSY, 0);

        // T5
        s0 = sready_cnt;
        start_job(0); finish_job(0, 0, res);
        cmp("t5_rdata", res, 48'h0);
        cmp("t5_no_sready", sready_cnt - s0, 0);

        // T6
        load_t2(); h0 = hs_cnt;
        start_job(4); feed(2, 0);
        RST = 0; @(posedge CLK); #1; RST = 1;
        @(negedge CLK);
        cmp("t6_busy", BUSY, 0);   cmp("t6_sready", S_READY, 0);
        cmp("t6_mrst", MACC_RST, 1); cmp("t6_macc_a", MACC_A, 0);
        cmp("t6_rvalid", R_VALID, 0); cmp("t6_rdata", R_DATA, 0);
        v0 = rvalid_cnt;
        repeat (20) @(posedge CLK);
        #1;
        cmp("t6_no_result", rvalid_cnt - v0, 0);
        cmp("t6_no_hs", hs_cnt - h0, 0);
        load_t2(); start_job(4); feed(4, 0); finish_job(0, 0, res);
        cmp("t6_rerun", res, 48'h2F4A53);

        // Randomized jobs
        for (int j = 0; j < 12; j++) begin
            int len;
            len = $urandom_range(0, 12);
            clr_q();
            for (int i = 0; i < len; i++) push(18'($urandom), 18'($urandom), 1'($urandom));
            h0 = hs_cnt;
            start_job(len); feed(len, 2);
            finish_job($urandom_range(0, 3), 1'($urandom), res);
            cmp("rnd_results", hs_cnt - h0, 1);
        end

        repeat (4) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
